// File: rtl/i2c_byte_master.sv
// i2c_byte_master: single-byte I2C master sequencing START / 8 data bits / ACK / STOP on quarter-bit ticks
// Ports: clk, rst_n (async, active-low); div_clk (4x SCL rate, quarter-bit ticks);
//   cmd_valid/cmd_ready handshake with cmd_start, cmd_stop, cmd_read, tx_data, tx_nack;
//   rx_data, rx_nack, done (one-clk pulse), busy; scl_oe/sda_oe open-drain pulls (1 = low); sda_i line level.
module i2c_byte_master #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       div_clk,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic [7:0] tx_data,
  input  logic       tx_nack,
  output logic [7:0] rx_data,
  output logic       rx_nack,
  output logic       done,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] cnt_q, cnt_d;
  logic stop_q, stop_d, read_q, read_d, txn_q, txn_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d;
  logic nack_q, nack_d, done_q, done_d, ready_q, ready_d;
  logic scl_q, scl_d, sda_q, sda_d;
  logic [SYNC_STAGES-1:0] ds_q;
  logic dprev_q;
  logic [1:0] si_q;
  logic qtick, accept, sda_s;
  assign qtick = ds_q[SYNC_STAGES-1] & ~dprev_q;
  assign sda_s = si_q[1];
  assign accept = cmd_valid & ready_q;
  assign cmd_ready = ready_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign rx_data = rx_q;
  assign rx_nack = nack_q;
  assign scl_oe = scl_q;
  assign sda_oe = sda_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q <= '0;
      cnt_q <= '0;
      stop_q <= 1'b0;
      read_q <= 1'b0;
      txn_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      nack_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b0;
      scl_q <= 1'b0;
      sda_q <= 1'b0;
      ds_q <= '0;
      dprev_q <= 1'b0;
      si_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      stop_q <= stop_d;
      read_q <= read_d;
      txn_q <= txn_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      nack_q <= nack_d;
      done_q <= done_d;
      ready_q <= ready_d;
      scl_q <= scl_d;
      sda_q <= sda_d;
      ds_q <= {ds_q[SYNC_STAGES-2:0], div_clk};
      dprev_q <= ds_q[SYNC_STAGES-1];
      si_q <= {si_q[0], sda_i};
    end
  end
  // Acceptance enters q0 of the first phase immediately; each qtick then advances one quarter,
  // and the qtick that would leave the last q3 is the finishing one.
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    cnt_d = cnt_q;
    stop_d = stop_q;
    read_d = read_q;
    txn_d = txn_q;
    tx_d = tx_q;
    rx_d = rx_q;
    nack_d = nack_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = cmd_start ? START : BIT;
        ph_d = 2'd0;
        cnt_d = 3'd7;
        stop_d = cmd_stop;
        read_d = cmd_read;
        txn_d = tx_nack;
        tx_d = tx_data;
      end
    end else if (qtick) begin
      ph_d = ph_q + 2'd1;
      if (ph_q == 2'd1 && state_q == BIT && read_q) rx_d[cnt_q] = sda_s;
      if (ph_q == 2'd1 && state_q == ACK) nack_d = ~read_q & sda_s;
      if (ph_q == 2'd3) begin
        case (state_q)
          START: state_d = BIT;
          BIT: begin
            state_d = (cnt_q == 3'd0) ? ACK : BIT;
            cnt_d = cnt_q - 3'd1;
          end
          ACK: state_d = stop_q ? STOP : IDLE;
          default: state_d = IDLE;
        endcase
        done_d = (state_d == IDLE);
      end
    end
    ready_d = (state_d == IDLE) & ~done_d;
  end
  // Line drives are derived from the upcoming phase so the registered pulls change on the qtick itself;
  // IDLE keeps whatever level the last phase left on the bus.
  always_comb begin
    scl_d = scl_q;
    sda_d = sda_q;
    case (state_d)
      START: begin
        scl_d = (ph_d == 2'd3);
        sda_d = (ph_d != 2'd0);
      end
      BIT: begin
        scl_d = (ph_d == 2'd0) || (ph_d == 2'd3);
        sda_d = ~read_d & ~tx_d[cnt_d];
      end
      ACK: begin
        scl_d = (ph_d == 2'd0) || (ph_d == 2'd3);
        sda_d = read_d & ~txn_d;
      end
      STOP: begin
        scl_d = (ph_d == 2'd0);
        sda_d = (ph_d < 2'd2);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: directed bench for i2c_byte_master with a simple slave and bus monitor
module tb_i2c_byte_master;
  localparam int SS = 2;
  logic clk = 0, rst_n = 1, div_clk = 0;
  logic cmd_valid = 0, cmd_start = 0, cmd_stop = 0, cmd_read = 0, tx_nack = 0;
  logic [7:0] tx_data = 0;
  logic cmd_ready, done, busy, scl_oe, sda_oe, rx_nack;
  logic [7:0] rx_data;
  logic scl, sda, sda_i, slave_pull;
  int total = 0, bad = 0;

  assign scl = ~scl_oe;
  assign sda = ~(sda_oe | slave_pull);
  assign sda_i = sda;

  always #5 clk = ~clk;
  always #40 div_clk = ~div_clk;

  i2c_byte_master #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_read(cmd_read), .tx_data(tx_data), .tx_nack(tx_nack),
    .rx_data(rx_data), .rx_nack(rx_nack), .done(done), .busy(busy),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  // independent quarter-tick reference: m_qt high means the next clk edge carries a qtick
  logic [SS-1:0] m_ds = '0;
  logic m_prev = 0, m_qt;
  always @(posedge clk) begin
    m_ds <= {m_ds[SS-2:0], div_clk};
    m_prev <= m_ds[SS-1];
  end
  assign m_qt = m_ds[SS-1] & ~m_prev;

  // slave: mode 0 silent, 1 ACKs a written byte, 2 drives s_byte MSB first; changes SDA on SCL falls
  int rise_cnt = 0, fall_rise = 0, base = 0, s_mode = 0, idx;
  logic [7:0] s_byte = 0;
  logic [2:0] bi;
  logic [31:0] cap = 0;
  always @(posedge scl) begin
    rise_cnt++;
    cap = {cap[30:0], sda};
  end
  always @(negedge scl) fall_rise = rise_cnt;
  assign idx = fall_rise - base;
  assign bi = 3'(7 - idx);
  assign slave_pull = (s_mode == 2) ? (idx >= 0 && idx < 8 && !s_byte[bi]) : (s_mode == 1 && idx == 8);

  // bus monitor: SDA edges while SCL stays high are START (fall) or STOP (rise)
  int starts = 0, stops = 0, dones = 0, accepts = 0, rb_vio = 0;
  logic p_scl = 0, p_sda = 0;
  always @(negedge clk) begin
    if (p_scl === 1'b1 && scl === 1'b1 && sda !== p_sda) begin
      if (sda === 1'b0) starts++;
      else stops++;
    end
    p_scl = scl;
    p_sda = sda;
    if (done === 1'b1) dones++;
    if (busy === 1'b1 && cmd_ready === 1'b1) rb_vio++;
  end
  always @(posedge clk) if (cmd_valid && cmd_ready === 1'b1) accepts++;

  task automatic arm(input int mode, input logic [7:0] b);
    s_byte = b;
    base = rise_cnt;
    s_mode = mode;
  endtask

  task automatic run_cmd(input logic st, input logic sp, input logic rd, input logic [7:0] tx,
                         input logic tn, output int q, output logic ok);
    int n;
    @(negedge clk);
    cmd_start = st; cmd_stop = sp; cmd_read = rd; tx_data = tx; tx_nack = tn; cmd_valid = 1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    q = 0;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      if (m_qt) q++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    total++; if (scl_oe !== 1'b0) begin bad++; $display("FAIL rst_scl_oe got=%b exp=0", scl_oe); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    total++; if (rx_nack !== 1'b0) begin bad++; $display("FAIL rst_rx_nack got=%b exp=0", rx_nack); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b exp=1", cmd_ready); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_start_write_stop();
    int q, s0, p0, d0;
    logic ok;
    logic [31:0] c;
    arm(1, 8'h00);
    s0 = starts; p0 = stops; d0 = dones;
    run_cmd(1, 1, 0, 8'hA5, 0, q, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL sws_done got=%b exp=1", ok); end
    total++; if (q !== 44) begin bad++; $display("FAIL sws_qticks got=%0d exp=44", q); end
    total++; if (rx_nack !== 1'b0) begin bad++; $display("FAIL sws_rx_nack got=%b exp=0", rx_nack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sws_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL sws_done_width got=%b exp=0", done); end
    repeat (2) @(negedge clk);
    c = cap;
    total++; if (rise_cnt - base !== 10) begin bad++; $display("FAIL sws_scl_rises got=%0d exp=10", rise_cnt - base); end
    total++; if (c[9:2] !== 8'hA5) begin bad++; $display("FAIL sws_bits got=%h exp=a5", c[9:2]); end
    total++; if (c[1] !== 1'b0) begin bad++; $display("FAIL sws_ack_bit got=%b exp=0", c[1]); end
    total++; if (starts - s0 !== 1) begin bad++; $display("FAIL sws_starts got=%0d exp=1", starts - s0); end
    total++; if (stops - p0 !== 1) begin bad++; $display("FAIL sws_stops got=%0d exp=1", stops - p0); end
    total++; if (dones - d0 !== 1) begin bad++; $display("FAIL sws_done_pulses got=%0d exp=1", dones - d0); end
    total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL sws_idle_lines got=%b exp=00", {scl_oe, sda_oe}); end
  endtask

  task automatic test_write_nostop();
    int q, s0, p0;
    logic ok;
    logic [31:0] c;
    arm(0, 8'h00);
    s0 = starts; p0 = stops;
    run_cmd(0, 0, 0, 8'h3C, 0, q, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr_done got=%b exp=1", ok); end
    total++; if (q !== 36) begin bad++; $display("FAIL wr_qticks got=%0d exp=36", q); end
    total++; if (rx_nack !== 1'b1) begin bad++; $display("FAIL wr_rx_nack got=%b exp=1", rx_nack); end
    repeat (3) @(negedge clk);
    c = cap;
    total++; if (scl_oe !== 1'b1) begin bad++; $display("FAIL wr_scl_low got=%b exp=1", scl_oe); end
    total++; if (c[8:1] !== 8'h3C) begin bad++; $display("FAIL wr_bits got=%h exp=3c", c[8:1]); end
    total++; if (starts - s0 + stops - p0 !== 0) begin bad++; $display("FAIL wr_start_stop got=%0d exp=0", starts - s0 + stops - p0); end
  endtask

  task automatic test_read_stop();
    int q, s0, p0;
    logic ok;
    logic [31:0] c;
    arm(2, 8'h96);
    s0 = starts; p0 = stops;
    run_cmd(0, 1, 1, 8'h00, 1, q, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rd_done got=%b exp=1", ok); end
    total++; if (q !== 40) begin bad++; $display("FAIL rd_qticks got=%0d exp=40", q); end
    total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL rd_rx_data got=%h exp=96", rx_data); end
    total++; if (rx_nack !== 1'b0) begin bad++; $display("FAIL rd_rx_nack got=%b exp=0", rx_nack); end
    repeat (3) @(negedge clk);
    c = cap;
    total++; if (c[9:2] !== 8'h96) begin bad++; $display("FAIL rd_bus_bits got=%h exp=96", c[9:2]); end
    total++; if (c[1] !== 1'b1) begin bad++; $display("FAIL rd_master_nack got=%b exp=1", c[1]); end
    total++; if (stops - p0 !== 1) begin bad++; $display("FAIL rd_stops got=%0d exp=1", stops - p0); end
    total++; if (starts - s0 !== 0) begin bad++; $display("FAIL rd_starts got=%0d exp=0", starts - s0); end
  endtask

  task automatic test_back_to_back();
    int a0, v0, d0, seen;
    arm(0, 8'h00);
    @(negedge clk);
    a0 = accepts; v0 = rb_vio; d0 = dones;
    cmd_start = 0; cmd_stop = 0; cmd_read = 0; tx_data = 8'h11; tx_nack = 0; cmd_valid = 1;
    seen = 0;
    for (int i = 0; i < 3000 && seen < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    cmd_valid = 0;
    repeat (4) @(negedge clk);
    total++; if (seen !== 2) begin bad++; $display("FAIL b2b_dones got=%0d exp=2", seen); end
    total++; if (accepts - a0 !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", accepts - a0); end
    total++; if (rb_vio - v0 !== 0) begin bad++; $display("FAIL b2b_ready_while_busy got=%0d exp=0", rb_vio - v0); end
    total++; if (dones - d0 !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d exp=2", dones - d0); end
  endtask

  task automatic test_reset_mid();
    int d0, n, q;
    logic ok;
    arm(0, 8'h00);
    d0 = dones;
    @(negedge clk);
    cmd_start = 0; cmd_stop = 0; cmd_read = 0; tx_data = 8'hA5; tx_nack = 0; cmd_valid = 1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (rise_cnt - base < 4 && n < 1000) begin @(negedge clk); n++; end
    while (scl !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    total++; if ({scl_oe, sda_oe} !== 2'b11) begin bad++; $display("FAIL rm_pre_lines got=%b exp=11", {scl_oe, sda_oe}); end
    #3 rst_n = 0;
    #1;
    total++; if (scl_oe !== 1'b0) begin bad++; $display("FAIL rm_scl_release got=%b exp=0", scl_oe); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rm_sda_release got=%b exp=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_after got=%b exp=1", cmd_ready); end
    total++; if (dones - d0 !== 0) begin bad++; $display("FAIL rm_no_done got=%0d exp=0", dones - d0); end
    repeat (4) @(negedge clk);
    arm(1, 8'h00);
    run_cmd(0, 0, 0, 8'h3C, 0, q, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rm_next_done got=%b exp=1", ok); end
    total++; if (q !== 36) begin bad++; $display("FAIL rm_next_qticks got=%0d exp=36", q); end
    total++; if (rx_nack !== 1'b0) begin bad++; $display("FAIL rm_next_rx_nack got=%b exp=0", rx_nack); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_start_write_stop();
    test_write_nostop();
    test_read_stop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
